seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised multi-digit seven-segment display driver for the clock/display datapath. It accepts a binary value through a load strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one shared segment bus with a digit-enable scan. It generalises the fixed two-digit 0..12 encoder with:
- N digits
- leading-zero blanking
- overflow indication
- selectable output polarity

Parameters:
NUM_DIGITS, 4, number of displayed decimal digits (1..8)
VALUE_W, 14, width of binary input value
REFRESH_DIV, 50000, clk cycles per digit slot in the scan (>=2)
ACTIVE_LOW, 1, 1: seg/an low = lit/selected; 0: outputs inverted
BLANK_LEADING, 1, 1: blank leading zero digits; 0: show all zeros

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; capture value when not busy
value  in  VALUE_W  binary value to display, unsigned
busy  out  1  conversion in progress
ovf  out  1  last loaded value exceeded 10^NUM_DIGITS-1
seg  out  7  segments, bit order abcdefg (seg[6]=a)
an  out  NUM_DIGITS  one-hot digit enable, an[0]=least significant digit

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - busy=0, ovf=0
  - BCD display register = all zeros
  - prescaler=0, digit index=0
  - an = digit 0 selected (ACTIVE_LOW: ...1110)
  - seg = pattern for '0' (ACTIVE_LOW: 7'b0000001)
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 captures value into the shift register, clears the BCD scratch, and sets the overflow flag candidate (value > 10^NUM_DIGITS-1; a localparam computed by function). Goes to SHIFT; busy=1 from the next cycle.
  - SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every scratch nibble >=5, then shift left one bit with the binary MSB entering. Bit counter is $clog2(VALUE_W+1) wide.
  - DONE: one cycle. Copies scratch into the display register and the overflow candidate into ovf, atomically. busy=0 next cycle; return to IDLE.
  - Total: load at cycle t -> display register and ovf valid at t+VALUE_W+2; busy high for VALUE_W+1 cycles.
- load while busy=1 is ignored. No queueing, no effect on the in-flight conversion.
- During conversion the display keeps showing the previous value. There is no tearing.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 free-running, independent of the FSM.
  - At terminal count, digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - seg/an are registered: one cycle latency from index/display-register change.
- Digit content, with priority order:
  1. ovf=1: every digit shows dash (g only; ACTIVE_LOW 7'b1111110).
  2. BLANK_LEADING=1 and digit k>0 and digits k..NUM_DIGITS-1 are all zero: blank (all segments off).
  3. Otherwise: decimal glyph.
  - Digit 0 is never blanked; value 0 shows '0'.
- BCD nibble values 10..15 cannot occur. The decoder maps them to blank (defensive).
- ACTIVE_LOW=0 inverts both seg and an at the output register only.
- Reset mid-conversion aborts immediately. The previous display contents are lost (display register zeroed).

Decomposition:
- Package seg7_pkg holds:
  - glyph constants for 0-9, DASH, BLANK (active-low abcdefg form)
  - FSM state typedef (IDLE/SHIFT/DONE)
  - function pow10 for the overflow limit
- One sub-module: bin2bcd_seq, parametrised by VALUE_W and NUM_DIGITS. It contains the FSM and shift-add-3 engine, with a load/busy/done interface.
- The scan, blanking and decode logic stays in the top module.

Test Plan:
- Sim parameters: NUM_DIGITS=4, VALUE_W=14, REFRESH_DIV=4, ACTIVE_LOW=1, BLANK_LEADING=1.
- Reset: hold rst_n=0 mid-cycle -> outputs change without a clock edge. an=4'b1110, seg=7'b0000001, busy=0, ovf=0. Over 16 cycles, digits 1..3 show seg=7'b1111111.
- load value=1234 -> busy high for exactly 15 cycles. From cycle t+16 the scan shows:
  - an=1110 seg=1001100 (4)
  - an=1101 seg=0000110 (3)
  - an=1011 seg=0010010 (2)
  - an=0111 seg=1001111 (1)
- load value=5 -> digit0 seg=7'b0100100; digits 1..3 blank. Rerun with BLANK_LEADING=0 -> digits 1..3 show 7'b0000001.
- load value=12000 -> ovf=1; all four digits seg=7'b1111110. Then load 9999 -> ovf=0 and all digits show 7'b0000100.
- load 42, then load 77 three cycles later (busy=1) -> 77 ignored; display settles to 42. The old value stays on the display during the first conversion.
- load 500, then assert rst_n=0 at the 6th SHIFT cycle -> busy=0 immediately and the display shows '0'. After release, load 321 -> correct display of 321.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared glyphs, converter state type and helpers for the
//           seven-segment scan driver.
// Rev     : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Glyphs are held active-low in abcdefg order (bit 6 = segment a).
    localparam logic [6:0] c_GLYPH_0     = 7'b0000001;
    localparam logic [6:0] c_GLYPH_1     = 7'b1001111;
    localparam logic [6:0] c_GLYPH_2     = 7'b0010010;
    localparam logic [6:0] c_GLYPH_3     = 7'b0000110;
    localparam logic [6:0] c_GLYPH_4     = 7'b1001100;
    localparam logic [6:0] c_GLYPH_5     = 7'b0100100;
    localparam logic [6:0] c_GLYPH_6     = 7'b0100000;
    localparam logic [6:0] c_GLYPH_7     = 7'b0001111;
    localparam logic [6:0] c_GLYPH_8     = 7'b0000000;
    localparam logic [6:0] c_GLYPH_9     = 7'b0000100;
    localparam logic [6:0] c_GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] c_GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = c_GLYPH_0;
            4'd1:    g = c_GLYPH_1;
            4'd2:    g = c_GLYPH_2;
            4'd3:    g = c_GLYPH_3;
            4'd4:    g = c_GLYPH_4;
            4'd5:    g = c_GLYPH_5;
            4'd6:    g = c_GLYPH_6;
            4'd7:    g = c_GLYPH_7;
            4'd8:    g = c_GLYPH_8;
            4'd9:    g = c_GLYPH_9;
            default: g = c_GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Sequential shift-add-3 binary to BCD converter with load/busy/done.
// Rev     : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_ovf
);

    localparam int                 c_BCD_W = 4 * NUM_DIGITS;
    localparam int                 c_CNT_W = $clog2(VALUE_W + 1);
    localparam logic [63:0]        c_MAX   = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(VALUE_W - 1);

    conv_state_t        r_state;
    logic [VALUE_W-1:0] r_bin;
    logic [c_BCD_W-1:0] r_scratch;
    logic [c_BCD_W-1:0] w_adj;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_ovf_cand;
    logic               w_ovf_cand;

    assign w_ovf_cand = (64'(i_value) > c_MAX);

    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_ovf_cand <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_bin      <= i_value;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_cand <= w_ovf_cand;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Binary MSB enters the BCD scratch after the add-3 correction.
                    r_scratch <= (w_adj << 1) | c_BCD_W'(r_bin[VALUE_W-1]);
                    r_bin     <= r_bin << 1;
                    r_cnt     <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = (r_state == ST_DONE);
    assign o_bcd  = r_scratch;
    assign o_ovf  = r_ovf_cand;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : N-digit multiplexed seven-segment driver with BCD conversion,
//           leading-zero blanking, overflow dashes and selectable polarity.
// Rev     : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV   = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int                    c_BCD_W    = 4 * NUM_DIGITS;
    localparam int                    c_PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int                    c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_SEL0     = NUM_DIGITS'(1);
    localparam logic [6:0]            c_SEG_RST  = (ACTIVE_LOW != 0) ? c_GLYPH_0 : ~c_GLYPH_0;
    localparam logic [NUM_DIGITS-1:0] c_AN_RST   = (ACTIVE_LOW != 0) ? ~c_SEL0 : c_SEL0;

    logic                  w_busy;
    logic                  w_done;
    logic [c_BCD_W-1:0]    w_bcd;
    logic                  w_ovf_cand;

    logic [c_BCD_W-1:0]    r_disp;
    logic                  r_ovf;
    logic [c_PRE_W-1:0]    r_presc;
    logic [c_IDX_W-1:0]    r_digit;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic [NUM_DIGITS-1:0] w_zero;
    logic [NUM_DIGITS-1:0] w_sel;
    logic [3:0]            w_nib;
    logic                  w_upper_zero;
    logic [6:0]            w_glyph;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (load),
        .i_value (value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf_cand)
    );

    // The display register only changes on done, so a conversion never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_done) begin
            r_disp <= w_bcd;
            r_ovf  <= w_ovf_cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == c_PRE_LAST) begin
            r_presc <= '0;
            r_digit <= (r_digit == c_IDX_LAST) ? '0 : r_digit + c_IDX_W'(1);
        end else begin
            r_presc <= r_presc + c_PRE_W'(1);
        end
    end

    // w_zero[k]: digits k and above are all zero.
    always_comb begin
        w_zero = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_zero[k] = ((r_disp >> (4 * k)) == '0);
        end
    end

    always_comb begin
        w_sel        = '0;
        w_nib        = 4'd0;
        w_upper_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digit == c_IDX_W'(k)) begin
                w_sel[k]     = 1'b1;
                w_nib        = r_disp[4*k +: 4];
                w_upper_zero = w_zero[k];
            end
        end
    end

    always_comb begin
        if (r_ovf) begin
            w_glyph = c_GLYPH_DASH;
        end else if ((BLANK_LEADING != 0) && (r_digit != '0) && w_upper_zero) begin
            w_glyph = c_GLYPH_BLANK;
        end else begin
            w_glyph = glyph(w_nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_SEG_RST;
            r_an  <= c_AN_RST;
        end else begin
            r_seg <= (ACTIVE_LOW != 0) ? w_glyph : ~w_glyph;
            r_an  <= (ACTIVE_LOW != 0) ? ~w_sel : w_sel;
        end
    end

    assign busy = w_busy;
    assign ovf  = r_ovf;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Self-checking bench; two drivers (with/without blanking) share stimulus.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int VW = 14;
    localparam int RD = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          load  = 1'b0;
    logic [VW-1:0] value = '0;

    logic          busy_a, ovf_a, busy_b, ovf_b;
    logic [6:0]    seg_a, seg_b;
    logic [ND-1:0] an_a, an_b;

    int n_checks = 0;
    int n_fail   = 0;
    int shown    = 0;

    typedef struct {
        int          val;
        logic        exp_ovf;
        logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy_a), .ovf(ovf_a), .seg(seg_a), .an(an_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEADING(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .busy(busy_b), .ovf(ovf_b), .seg(seg_b), .an(an_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int d);
        logic [6:0] g;
        case (d)
            0: g = 7'b0000001;
            1: g = 7'b1001111;
            2: g = 7'b0010010;
            3: g = 7'b0000110;
            4: g = 7'b1001100;
            5: g = 7'b0100100;
            6: g = 7'b0100000;
            7: g = 7'b0001111;
            8: g = 7'b0000000;
            default: g = 7'b0000100;
        endcase
        return g;
    endfunction

    // Expected segments for digit k of decimal value v.
    function automatic logic [6:0] model_seg(input int v, input int k, input bit bl);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v > 9999) return 7'b1111110;
        if (bl && k > 0 && v < p) return 7'b1111111;
        return glyph_of((v / p) % 10);
    endfunction

    task automatic check_hold();
        for (int i = 0; i < ND; i++) begin
            if (an_a[i] == 1'b0) begin
                chk("hold_seg", {25'd0, seg_a}, {25'd0, model_seg(shown, i, 1)});
                chk("hold_seg_noblank", {25'd0, seg_b}, {25'd0, model_seg(shown, i, 0)});
            end
        end
        chk("hold_ovf", {31'd0, ovf_a}, {31'd0, shown > 9999});
    endtask

    task automatic check_scan(input int v, input bit use_tab, input logic [27:0] tab);
        logic [ND-1:0] seen;
        logic [6:0]    exp;
        int k, nz, prev_k, run;
        bit first_run;
        seen = '0; prev_k = -1; run = 0; first_run = 1;
        for (int c = 0; c < 3 * ND * RD; c++) begin
            @(negedge clk);
            k = -1; nz = 0;
            for (int i = 0; i < ND; i++) begin
                if (an_a[i] == 1'b0) begin k = i; nz++; end
            end
            chk("an_onehot", nz, 1);
            chk("an_noblank", {28'd0, an_b}, {28'd0, an_a});
            if (k >= 0) begin
                seen[k] = 1'b1;
                exp = use_tab ? tab[7*k +: 7] : model_seg(v, k, 1);
                chk("seg_blank", {25'd0, seg_a}, {25'd0, exp});
                chk("seg_noblank", {25'd0, seg_b}, {25'd0, model_seg(v, k, 0)});
                if (k == prev_k) begin
                    run++;
                end else begin
                    if (prev_k >= 0) begin
                        chk("digit_order", k, (prev_k + 1) % ND);
                        if (!first_run) chk("slot_len", run, RD);
                        first_run = 0;
                    end
                    prev_k = k;
                    run = 1;
                end
            end
        end
        chk("digits_seen", {28'd0, seen}, 32'hF);
        chk("ovf", {31'd0, ovf_a}, {31'd0, v > 9999});
        chk("ovf_noblank", {31'd0, ovf_b}, {31'd0, v > 9999});
    endtask

    task automatic load_and_wait(input int v);
        int n;
        @(negedge clk);
        value = VW'(v);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            check_hold();
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, VW + 1);
        shown = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_an"}, {28'd0, an_a}, 32'b1110);
        chk({tag, "_seg"}, {25'd0, seg_a}, 32'b0000001);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf_a}, 32'd0);
        chk({tag, "_seg_nb"}, {25'd0, seg_b}, 32'b0000001);
        chk({tag, "_busy_nb"}, {31'd0, busy_b}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, v;

        vecs[0] = '{1234,  1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[1] = '{5,     1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}};
        vecs[2] = '{12000, 1'b1, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[3] = '{9999,  1'b0, {7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100}};
        vecs[4] = '{1000,  1'b0, {7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}};
        vecs[5] = '{10000, 1'b1, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}};
        vecs[6] = '{0,     1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};

        // Asynchronous reset applied mid-cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        shown = 0;
        check_scan(0, 1'b0, '0);

        foreach (vecs[i]) begin
            load_and_wait(vecs[i].val);
            chk("tab_ovf", {31'd0, ovf_a}, {31'd0, vecs[i].exp_ovf});
            check_scan(vecs[i].val, 1'b1, vecs[i].exp_seg);
        end

        // A second load while busy is dropped.
        @(negedge clk);
        value = VW'(42);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            check_hold();
            if (n == 2) begin
                value = VW'(77);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        load = 1'b0;
        chk("busy_len_ignore", n, VW + 1);
        shown = 42;
        repeat (3) @(negedge clk);
        chk("no_queued_load", {31'd0, busy_a}, 32'd0);
        check_scan(42, 1'b0, '0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        value = VW'(500);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_before_abort", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        #1 check_reset_state("abort");
        repeat (3) @(negedge clk);
        check_reset_state("abort_hold");
        rst_n = 1'b1;
        shown = 0;
        check_scan(0, 1'b0, '0);
        load_and_wait(321);
        check_scan(321, 1'b0, '0);

        // Randomised values against the decimal model.
        for (int r = 0; r < 14; r++) begin
            case ($urandom % 3)
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 16383));
            endcase
            load_and_wait(v);
            check_scan(v, 1'b0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
